cpu_subsys_bus_fabric: RTL and testbench

Parametrised data-side interconnect for the CPU subsystem. It connects one Ibex-style master port (req/gnt/rvalid/err) to NUM_SLAVES valid/ready slave ports, such as ROM, SRAM and peripherals. It adds what the fixed host bridge lacks:
- a real grant handshake
- a configurable address map
- a decode-error response
- a per-access timeout with bus-error return
It sits between the core's data port and the memory/peripheral slaves.

---
 rtl/cpu_subsys_bus_pkg.sv | 22 ++
 rtl/cpu_subsys_addr_decode.sv | 27 ++
 rtl/cpu_subsys_bus_fabric.sv | 166 ++++++++++++++++
 tb/tb_cpu_subsys_bus_fabric.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_subsys_bus_pkg.sv
// Shared types and default address map for the CPU subsystem data-side fabric.
package cpu_subsys_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } fabric_state_e;

  // Width of a slave index; a single-slave fabric still carries a 1-bit index.
  function automatic int sel_width(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

  localparam logic [31:0] ROM_BASE    = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK    = 32'hFFFF_0000;
  localparam logic [31:0] SRAM_BASE   = 32'h1000_0000;
  localparam logic [31:0] SRAM_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] PERIPH_BASE = 32'h2000_0000;
  localparam logic [31:0] PERIPH_MASK = 32'hF000_0000;

endpackage

// File: rtl/cpu_subsys_addr_decode.sv
// Combinational priority address decoder; on overlapping regions the lowest slave index wins.
module cpu_subsys_addr_decode
  import cpu_subsys_bus_pkg::*;
#(
  parameter int                     NUM_SLAVES = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = {PERIPH_BASE, SRAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {PERIPH_MASK, SRAM_MASK, ROM_MASK},
  localparam int                    SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic [SEL_W-1:0] sel_o
);

  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    // Walk from the top index down so the lowest matching index is left standing.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit_o = 1'b1;
        sel_o = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_subsys_bus_fabric.sv
// Data-side interconnect: one req/gnt/rvalid master to NUM_SLAVES valid/ready slaves,
// with address decode, decode-error response and per-access timeout.
//
// state  | meaning
// IDLE   | grant follows request; latch access and decode
// ACCESS | one slave valid held high until ready or timeout
// RESP   | single-cycle rvalid with err/rdata, no grant
module cpu_subsys_bus_fabric
  import cpu_subsys_bus_pkg::*;
#(
  parameter int                       NUM_SLAVES     = 3,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE       = {PERIPH_BASE, SRAM_BASE, ROM_BASE},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK       = {PERIPH_MASK, SRAM_MASK, ROM_MASK},
  parameter int                       TIMEOUT_CYCLES = 256,
  parameter int                       TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       data_req_i,
  output logic                       data_gnt_o,
  output logic                       data_rvalid_o,
  output logic                       data_err_o,
  input  logic                       data_we_i,
  input  logic [3:0]                 data_be_i,
  input  logic [31:0]                data_addr_i,
  input  logic [31:0]                data_wdata_i,
  output logic [31:0]                data_rdata_o,
  output logic [NUM_SLAVES-1:0]      slv_valid_o,
  input  logic [NUM_SLAVES-1:0]      slv_ready_i,
  output logic [31:0]                slv_addr_o,
  output logic [31:0]                slv_wdata_o,
  output logic [3:0]                 slv_wstrb_o,
  input  logic [NUM_SLAVES*32-1:0]   slv_rdata_i
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  // A disabled timeout still needs a legal counter width.
  localparam int CNT_W = (TMO_W < 1) ? 1 : TMO_W;

  fabric_state_e            state_q, state_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [3:0]               strb_q, strb_d;
  logic                     we_q, we_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [NUM_SLAVES-1:0]    valid_q, valid_d;
  logic                     rvalid_q, rvalid_d;
  logic                     err_q, err_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [CNT_W-1:0]         tmo_cnt_q, tmo_cnt_d;

  logic                     dec_hit;
  logic [SEL_W-1:0]         dec_sel;
  logic                     tmo_hit;

  cpu_subsys_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK)
  ) u_addr_decode (
    .addr_i (data_addr_i),
    .hit_o  (dec_hit),
    .sel_o  (dec_sel)
  );

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    we_d      = we_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    tmo_cnt_d = tmo_cnt_q;

    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          addr_d    = data_addr_i;
          wdata_d   = data_wdata_i;
          strb_d    = data_we_i ? data_be_i : 4'b0000;
          we_d      = data_we_i;
          sel_d     = dec_sel;
          tmo_cnt_d = '0;
          if (dec_hit) begin
            valid_d          = '0;
            valid_d[dec_sel] = 1'b1;
            state_d          = ACCESS;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = RESP;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first so a completion on the last allowed cycle is not lost.
        if (slv_ready_i[sel_q]) begin
          valid_d  = '0;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : slv_rdata_i[32*sel_q +: 32];
          state_d  = RESP;
        end else if (tmo_hit) begin
          valid_d  = '0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      valid_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign data_gnt_o    = (state_q == IDLE) && data_req_i;
  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign slv_valid_o   = valid_q;
  assign slv_addr_o    = addr_q;
  assign slv_wdata_o   = wdata_q;
  assign slv_wstrb_o   = strb_q;

endmodule

// File: tb/tb_cpu_subsys_bus_fabric.sv
// Self-checking bench for cpu_subsys_bus_fabric: transaction-level timeline model plus literal pins.
module tb_cpu_subsys_bus_fabric;

  localparam int NS  = 3;
  localparam int TMO = 8;
  // Slave1 aliases 0x0000_xxxx and 0x1000_xxxx, overlapping slave0 in the low region.
  localparam logic [NS*32-1:0] BASE = {32'h2000_0000, 32'h0000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hF000_0000, 32'hEFFF_0000, 32'hFFFF_0000};

  logic              sys_clk;
  logic              rst_n;
  logic              data_req_i;
  logic              data_gnt_o;
  logic              data_rvalid_o;
  logic              data_err_o;
  logic              data_we_i;
  logic [3:0]        data_be_i;
  logic [31:0]       data_addr_i;
  logic [31:0]       data_wdata_i;
  logic [31:0]       data_rdata_o;
  logic [NS-1:0]     slv_valid_o;
  logic [NS-1:0]     slv_ready_i;
  logic [31:0]       slv_addr_o;
  logic [31:0]       slv_wdata_o;
  logic [3:0]        slv_wstrb_o;
  logic [NS*32-1:0]  slv_rdata_i;

  cpu_subsys_bus_fabric #(
    .NUM_SLAVES     (NS),
    .SLV_BASE       (BASE),
    .SLV_MASK       (MASK),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .data_req_i    (data_req_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_err_o    (data_err_o),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_addr_i   (data_addr_i),
    .data_wdata_i  (data_wdata_i),
    .data_rdata_o  (data_rdata_o),
    .slv_valid_o   (slv_valid_o),
    .slv_ready_i   (slv_ready_i),
    .slv_addr_o    (slv_addr_o),
    .slv_wdata_o   (slv_wdata_o),
    .slv_wstrb_o   (slv_wstrb_o),
    .slv_rdata_i   (slv_rdata_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          exp_gnt, exp_rvalid, exp_err, chk_bus, cmp_en;
  logic [NS-1:0] exp_valid;
  logic [31:0]   exp_rdata, exp_addr, exp_wdata;
  logic [3:0]    exp_wstrb;

  logic [NS-1:0] t_seen;
  int            t_nv, t_nrv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode: first region (lowest index) whose masked address equals its base.
  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[32*i +: 32]) == BASE[32*i +: 32]) return i;
    return -1;
  endfunction

  initial begin
    forever begin
      @(negedge sys_clk);
      if (rst_n && cmp_en) begin
        check("gnt",    32'(data_gnt_o),    32'(exp_gnt));
        check("valid",  32'(slv_valid_o),   32'(exp_valid));
        check("rvalid", 32'(data_rvalid_o), 32'(exp_rvalid));
        check("err",    32'(data_err_o),    32'(exp_err));
        check("rdata",  data_rdata_o,       exp_rdata);
        if (chk_bus) begin
          check("slv_addr",  slv_addr_o,        exp_addr);
          check("slv_wdata", slv_wdata_o,       exp_wdata);
          check("slv_wstrb", 32'(slv_wstrb_o),  32'(exp_wstrb));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic tally();
    t_seen = t_seen | slv_valid_o;
    if (|slv_valid_o) t_nv++;
    if (data_rvalid_o) t_nrv++;
  endtask

  task automatic clear_tally();
    t_seen = '0;
    t_nv   = 0;
    t_nrv  = 0;
  endtask

  task automatic idle(input int n, input logic [NS-1:0] rdy);
    for (int k = 0; k < n; k++) begin
      step();
      data_req_i  = 1'b0;
      slv_ready_i = rdy;
      exp_gnt = 1'b0; exp_valid = '0; exp_rvalid = 1'b0; exp_err = 1'b0; chk_bus = 1'b0;
      tally();
    end
  endtask

  // One access: grant cycle, then ready at valid cycle rdy_at (never if >= TMO), then response.
  // Returns positioned inside the response cycle, or inside valid cycle abort_at.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input int rdy_at, input logic [31:0] rd,
                         input logic hold, input int abort_at);
    int            sel, nvalid;
    logic          tmo;
    logic [NS-1:0] sb;
    clear_tally();
    sel = model_sel(addr);
    sb  = '0;
    if (sel >= 0) sb[sel] = 1'b1;
    step();
    data_req_i = 1'b1; data_addr_i = addr; data_we_i = we; data_be_i = be; data_wdata_i = wd;
    slv_ready_i = '0;
    slv_rdata_i = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    if (sel >= 0) slv_rdata_i[32*sel +: 32] = rd;
    exp_gnt = 1'b1; exp_valid = '0; exp_rvalid = 1'b0; exp_err = 1'b0; chk_bus = 1'b0;
    tally();
    step();
    exp_gnt = 1'b0;
    if (!hold) begin
      data_req_i = 1'b0; data_addr_i = ~addr; data_we_i = ~we; data_be_i = ~be; data_wdata_i = ~wd;
    end
    if (sel < 0) begin
      exp_rvalid = 1'b1; exp_err = 1'b1; exp_rdata = 32'h0;
      tally();
      return;
    end
    exp_addr  = addr;
    exp_wdata = wd;
    exp_wstrb = we ? be : 4'b0000;
    tmo       = (rdy_at >= TMO);
    nvalid    = tmo ? TMO : rdy_at + 1;
    for (int i = 0; i < nvalid; i++) begin
      if (i > 0) step();
      exp_valid   = sb;
      chk_bus     = 1'b1;
      slv_ready_i = ~sb;
      if (i == rdy_at) slv_ready_i = slv_ready_i | sb;
      tally();
      if (i == abort_at) return;
    end
    step();
    slv_ready_i = ~sb;
    exp_valid = '0; chk_bus = 1'b0;
    exp_rvalid = 1'b1; exp_err = tmo;
    exp_rdata = (tmo || we) ? 32'h0 : rd;
    tally();
  endtask

  initial begin
    rst_n = 1'b0; cmp_en = 1'b0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_addr_i = '0; data_wdata_i = '0;
    slv_ready_i = '0; slv_rdata_i = '0;
    exp_gnt = 1'b0; exp_valid = '0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
    exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; chk_bus = 1'b0;
    clear_tally();

    #12;
    check("rst_gnt",    32'(data_gnt_o),    32'h0);
    check("rst_valid",  32'(slv_valid_o),   32'h0);
    check("rst_rvalid", 32'(data_rvalid_o), 32'h0);
    check("rst_err",    32'(data_err_o),    32'h0);
    check("rst_rdata",  data_rdata_o,       32'h0);
    check("rst_addr",   slv_addr_o,         32'h0);
    check("rst_wdata",  slv_wdata_o,        32'h0);
    check("rst_wstrb",  32'(slv_wstrb_o),   32'h0);
    step();
    rst_n = 1'b1; cmp_en = 1'b1;
    idle(1, '0);

    // SRAM read, ready on first valid cycle
    run_txn(32'h1000_0040, 1'b0, 4'hF, 32'h0, 0, 32'hCAFE_F00D, 1'b0, -1);
    check("t1_seen",   32'(t_seen),        32'h2);
    check("t1_nvalid", 32'(t_nv),          32'd1);
    check("t1_rvalid", 32'(data_rvalid_o), 32'h1);
    check("t1_rdata",  data_rdata_o,       32'hCAFE_F00D);
    check("t1_err",    32'(data_err_o),    32'h0);
    idle(1, '0);

    // unmapped address
    run_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0BAD_0BAD, 1'b0, -1);
    check("unm_seen",  32'(t_seen),     32'h0);
    check("unm_err",   32'(data_err_o), 32'h1);
    check("unm_rdata", data_rdata_o,    32'h0);
    check("unm_nrv",   32'(t_nrv),      32'd1);
    idle(1, '0);

    // ready and timeout on the same cycle: completion wins
    run_txn(32'h2ABC_0000, 1'b0, 4'hF, 32'h0, 7, 32'h600D_0006, 1'b0, -1);
    check("coin_nvalid", 32'(t_nv),       32'd8);
    check("coin_err",    32'(data_err_o), 32'h0);
    check("coin_rdata",  data_rdata_o,    32'h600D_0006);
    idle(2, '0);

    // write to peripheral, ready after 5 valid cycles
    run_txn(32'h2000_0004, 1'b1, 4'b0011, 32'h1234_5678, 4, 32'hDEAD_BEEF, 1'b0, -1);
    check("wr_seen",   32'(t_seen),     32'h4);
    check("wr_nvalid", 32'(t_nv),       32'd5);
    check("wr_nrv",    32'(t_nrv),      32'd1);
    check("wr_rdata",  data_rdata_o,    32'h0);
    idle(1, '0);

    // timeout on slave0, then a late ready must not produce a response
    run_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1000, 32'h1111_1111, 1'b0, -1);
    check("tmo_seen",   32'(t_seen),     32'h1);
    check("tmo_nvalid", 32'(t_nv),       32'd8);
    check("tmo_err",    32'(data_err_o), 32'h1);
    clear_tally();
    idle(2, '0);
    idle(1, 3'b001);
    idle(2, '0);
    check("late_nrv", 32'(t_nrv), 32'd0);
    check("late_nv",  32'(t_nv),  32'd0);

    // overlap (slave0 wins) and back-to-back requests with req held high
    run_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 2, 32'h0000_0A0A, 1'b1, -1);
    check("ovl_seen", 32'(t_seen), 32'h1);
    run_txn(32'h1000_0080, 1'b0, 4'hF, 32'h0, 1, 32'hB0B0_0001, 1'b1, -1);
    check("b2b_seen", 32'(t_seen), 32'h2);
    run_txn(32'h2000_0008, 1'b0, 4'hF, 32'h0, 0, 32'h7777_0007, 1'b0, -1);
    check("b2b_rdata", data_rdata_o, 32'h7777_0007);
    idle(1, '0);

    // reset in the middle of an access
    run_txn(32'h1000_0044, 1'b0, 4'hF, 32'h0, 1000, 32'h2222_2222, 1'b0, 2);
    #2;
    data_req_i = 1'b0; slv_ready_i = '0;
    rst_n = 1'b0;
    exp_gnt = 1'b0; exp_valid = '0; exp_rvalid = 1'b0; exp_err = 1'b0; exp_rdata = '0; chk_bus = 1'b0;
    #1;
    check("mid_rst_valid", 32'(slv_valid_o),   32'h0);
    check("mid_rst_gnt",   32'(data_gnt_o),    32'h0);
    check("mid_rst_rval",  32'(data_rvalid_o), 32'h0);
    check("mid_rst_rdata", data_rdata_o,       32'h0);
    check("mid_rst_addr",  slv_addr_o,         32'h0);
    step();
    rst_n = 1'b1;
    idle(1, '0);
    run_txn(32'h1000_0044, 1'b0, 4'hF, 32'h0, 1, 32'h5A5A_A5A5, 1'b0, -1);
    check("post_rst_seen",  32'(t_seen),     32'h2);
    check("post_rst_rdata", data_rdata_o,    32'h5A5A_A5A5);
    check("post_rst_err",   32'(data_err_o), 32'h0);
    idle(2, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
